// File: rtl/rca_pipe_if.sv
// rca_pipe_if: input/output handshake bundle for the pipelined ripple-carry adder.
// The ovf signal exists only when RCA_PIPE_OVF_EN is defined.
interface rca_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
`ifdef RCA_PIPE_OVF_EN
  logic             ovf;
`endif

  // Adder side: consumes operands, produces the sum.
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, s, cout
`ifdef RCA_PIPE_OVF_EN
    , output ovf
`endif
  );

  // Producer/consumer side: drives operands, takes the sum.
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, s, cout
`ifdef RCA_PIPE_OVF_EN
    , input ovf
`endif
  );
endinterface

// File: rtl/rca_pipe.sv
// rca_pipe: pipelined ripple-carry adder, s = a + b + cin (modulo 2^WIDTH), cout = bit WIDTH.
// WIDTH bits are split into STAGES chunks of WIDTH/STAGES bits; stage j ripples chunk j
// with the carry registered by stage j-1, so latency is STAGES cycles at one beat/cycle.
// Operands travel with their transaction so each stage finds its own chunk beside its carry.
// Each stage accepts a new beat whenever it is empty or its successor is moving, which
// collapses bubbles under backpressure.
// Optional feature: define RCA_PIPE_OVF_EN to add the signed-overflow output ovf.
module rca_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic       clk,
  input logic       rst,
  rca_pipe_if.slave bus
);
  localparam int C = WIDTH / STAGES;

  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_cfg_check
    $error("rca_pipe: need WIDTH >= 1, 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
  end

  // Index 0 of each array is the input side; index j+1 is what stage j holds.
  logic [STAGES:0]  rdy;
  logic [STAGES:0]  vl;
  logic [WIDTH-1:0] ps   [STAGES+1];
  logic             cy   [STAGES+1];
  // Operands seen by stage j: index 0 is the input bus, index j is stage j-1's copy.
  logic [WIDTH-1:0] op_a [STAGES];
  logic [WIDTH-1:0] op_b [STAGES];

  assign vl[0]   = bus.in_valid;
  assign ps[0]   = '0;
  assign cy[0]   = bus.cin;
  assign op_a[0] = bus.a;
  assign op_b[0] = bus.b;

  // Ready ripples backwards from the consumer; an empty stage is always ready.
  always_comb begin
    rdy[STAGES] = bus.out_ready;
    for (int j = STAGES - 1; j >= 0; j--) begin
      rdy[j] = !vl[j+1] || rdy[j+1];
    end
  end

  assign bus.in_ready = rdy[0] && !rst;

  for (genvar j = 0; j < STAGES; j++) begin : g_stage
    localparam int LO = j * C;

    logic             v_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_n;
    logic             c_q;
    logic             c_n;

    // Ripple this stage's chunk one bit at a time from the incoming carry.
    always_comb begin
      sum_n = ps[j];
      c_n   = cy[j];
      for (int k = 0; k < C; k++) begin
        sum_n[LO+k] = op_a[j][LO+k] ^ op_b[j][LO+k] ^ c_n;
        c_n         = (op_a[j][LO+k] & op_b[j][LO+k]) |
                      (c_n & (op_a[j][LO+k] ^ op_b[j][LO+k]));
      end
    end

    // Advance when there is room downstream; data is captured only with a real beat.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        sum_q <= '0;
        c_q   <= 1'b0;
      end else if (rdy[j]) begin
        v_q <= vl[j];
        if (vl[j]) begin
          sum_q <= sum_n;
          c_q   <= c_n;
        end
      end
    end

    assign vl[j+1] = v_q;
    assign ps[j+1] = sum_q;
    assign cy[j+1] = c_q;

    // The last stage consumes its operands, so only earlier stages forward them.
    if (j < STAGES - 1) begin : g_ops
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;

      // Operands ride along unmodified with their transaction.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (rdy[j] && vl[j]) begin
          a_q <= op_a[j];
          b_q <= op_b[j];
        end
      end

      assign op_a[j+1] = a_q;
      assign op_b[j+1] = b_q;
    end

`ifdef RCA_PIPE_OVF_EN
    if (j == STAGES - 1) begin : g_ovf
      logic ovf_q;
      logic c_msb;

      // Carry into the MSB recovered from the MSB's own sum bit.
      assign c_msb = sum_n[WIDTH-1] ^ op_a[j][WIDTH-1] ^ op_b[j][WIDTH-1];

      // Overflow is registered and stalled alongside s/cout.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (rdy[j] && vl[j]) begin
          ovf_q <= c_msb ^ c_n;
        end
      end

      assign bus.ovf = ovf_q;
    end
`endif
  end

  assign bus.out_valid = vl[STAGES];
  assign bus.s         = ps[STAGES];
  assign bus.cout      = cy[STAGES];
endmodule

// File: tb/tb_rca_pipe.sv
// tb_rca_pipe: scoreboard bench for rca_pipe (WIDTH=16, STAGES=4).
// The stimulus pushes the arithmetic result of every accepted beat; a separate monitor
// pops and compares whenever the adder hands a result to the consumer.
module tb_rca_pipe;
  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rca_pipe_if #(.WIDTH(WIDTH)) bus ();

  rca_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;
  bit   rnd_done;

  // Reference: plain integer arithmetic, signed overflow from the signed range.
  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic ci);
    res_t           r;
    logic [WIDTH:0] full;
    int             ssum;
    full   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    r.s    = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    ssum   = int'($signed(a)) + int'($signed(b)) + int'(ci);
    r.ovf  = (ssum > (2 ** (WIDTH - 1)) - 1) || (ssum < -(2 ** (WIDTH - 1)));
`ifndef RCA_PIPE_OVF_EN
    r.ovf  = 1'b0;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Present one beat and hold it until the adder takes it; the result is queued on accept.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci);
    int   n = 0;
    logic acc;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = ci;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (acc) begin
      exp_q.push_back(model(a, b, ci));
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout a=%0h b=%0h not accepted within 200 cycles", a, b);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_drain_left"}, exp_q.size(), 0);
  endtask

  // Monitor: compare every delivered result against the oldest outstanding expectation.
  initial begin
    res_t got;
    res_t exp;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        got.s    = bus.s;
        got.cout = bus.cout;
`ifdef RCA_PIPE_OVF_EN
        got.ovf  = bus.ovf;
`else
        got.ovf  = 1'b0;
`endif
        n_out++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got s=%0h cout=%0b with nothing outstanding",
                   got.s, got.cout);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL result got s=%0h cout=%0b ovf=%0b exp s=%0h cout=%0b ovf=%0b",
                     got.s, got.cout, got.ovf, exp.s, exp.cout, exp.ovf);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;

    // Reset and idle.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("in_ready_during_rst", bus.in_ready, 0);
    chk("out_valid_during_rst", bus.out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", bus.in_ready, 1);
    chk("out_valid_after_rst", bus.out_valid, 0);
    chk("s_after_rst", bus.s, 0);
    chk("cout_after_rst", bus.cout, 0);
`ifdef RCA_PIPE_OVF_EN
    chk("ovf_after_rst", bus.ovf, 0);
`endif

    // Single beat latency: 1 + 2 + 1.
    bus.out_ready = 1'b1;
    send(16'h0001, 16'h0002, 1'b1);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency_edges", lat, STAGES - 1);
    chk("latency_sum", bus.s, 16'h0004);
    chk("latency_cout", bus.cout, 0);
    drain("latency");

    // Carry boundary vectors, back to back.
    send(16'hFFFF, 16'h0001, 1'b0);
    send(16'hFFFF, 16'h0000, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0);
    send(16'h8000, 16'h8000, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1);
    send(16'h0000, 16'h0000, 1'b0);
    send(16'h00FF, 16'h0F01, 1'b0);
    drain("boundary");

    // Backpressure: fill to STAGES entries, stall, then release.
    bus.out_ready = 1'b0;
    n0 = n_out;
    for (int i = 1; i <= 4; i++) send(16'(i), 16'(i << 1), 1'b0);
    bus.in_valid = 1'b1;
    bus.a        = 16'd5;
    bus.b        = 16'd10;
    bus.cin      = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_full_in_ready", bus.in_ready, 0);
      chk("bp_hold_valid", bus.out_valid, 1);
      chk("bp_hold_s", bus.s, 3);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    #1;
    chk("bp_full_passthru_ready", bus.in_ready, 1);
    send(16'd5, 16'd10, 1'b0);
    send(16'd6, 16'd12, 1'b0);
    drain("bp");
    chk("bp_delivered", n_out - n0, 6);

    // Reset with three beats in flight.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("rst_mid_out_valid", bus.out_valid, 0);
    chk("rst_mid_s", bus.s, 0);
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    n0            = n_out;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_mid_no_stale", n_out - n0, 0);

    // Random operands with random input gaps and random backpressure.
    rnd_done = 1'b0;
    n0       = n_out;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
          end
          send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    drain("random");
    chk("random_delivered", n_out - n0, 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
